// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared data, register and tag types plus reset constants
package reorder_buffer_pkg;
  typedef logic [31:0] DATA_TYPE;
  typedef logic [4:0] REG_TYPE;
  typedef logic [4:0] ROB_ID_TYPE;
  localparam int ROB_SIZE = 16;
  localparam ROB_ID_TYPE ROB_ID_RESET = '0;
  localparam REG_TYPE REG_RESET = '0;
  localparam DATA_TYPE DATA_RESET = '0;
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement of out-of-order results with branch rollback
module reorder_buffer #(
  parameter int ROB_SIZE = reorder_buffer_pkg::ROB_SIZE,
  parameter int ROB_ID_W = 5
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rd,
  input  logic                issue_is_branch,
  input  logic                issue_pred_taken,
  input  logic [31:0]         issue_alt_pc,
  input  logic                issue_is_store,
  output logic [ROB_ID_W-1:0] new_rob_id,
  output logic                rob_full,
  input  logic [ROB_ID_W-1:0] query1_id,
  input  logic [ROB_ID_W-1:0] query2_id,
  output logic                query1_ready,
  output logic [31:0]         query1_value,
  output logic                query2_ready,
  output logic [31:0]         query2_value,
  input  logic                cdb_valid,
  input  logic [ROB_ID_W-1:0] cdb_rob_id,
  input  logic [31:0]         cdb_value,
  input  logic                cdb_taken,
  output logic                commit_flag,
  output logic [4:0]          commit_rd,
  output logic [31:0]         commit_value,
  output logic [ROB_ID_W-1:0] commit_rob_id,
  output logic                store_commit,
  output logic                rollback_flag,
  output logic [31:0]         rollback_pc
);
  import reorder_buffer_pkg::*;
  localparam int IW = $clog2(ROB_SIZE);
  localparam int CW = IW + 1;
  localparam logic [ROB_ID_W-1:0] ONE = ROB_ID_W'(1);
  localparam logic [ROB_ID_W-1:0] MAX_TAG = ROB_ID_W'(ROB_SIZE);
  localparam logic [CW-1:0] FULL_CNT = CW'(ROB_SIZE - 1);
  localparam logic [IW-1:0] STEP = IW'(1);

  function automatic logic [IW-1:0] slot(input logic [ROB_ID_W-1:0] t);
    return IW'(t - ONE);
  endfunction

  function automatic logic tag_ok(input logic [ROB_ID_W-1:0] t);
    return t != '0 && t <= MAX_TAG;
  endfunction

  logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;
  logic [ROB_SIZE-1:0] br_q, pt_q, tk_q, st_q;
  REG_TYPE             rd_q  [ROB_SIZE];
  DATA_TYPE            val_q [ROB_SIZE];
  DATA_TYPE            pc_q  [ROB_SIZE];
  logic [IW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                flush_q, flush_d;
  logic                cflag_q, cflag_d, cst_q, cst_d, rb_q, rb_d;
  REG_TYPE             crd_q, crd_d;
  DATA_TYPE            cval_q, cval_d, rbpc_q, rbpc_d;
  logic [ROB_ID_W-1:0] cid_q, cid_d;
  logic                live, do_issue, cdb_hit, do_commit, mispredict, auto_ready;
  logic [IW-1:0]       cslot, q1s, q2s;
  logic                q1_byp, q2_byp;

  // The cycle after a misprediction is spent flushing; nothing else may touch state then
  assign live       = rdy_in & ~flush_q;
  assign rob_full   = count_q >= FULL_CNT;
  assign new_rob_id = ROB_ID_W'(tail_q) + ONE;
  assign do_issue   = live & issue_valid & ~rob_full;
  assign auto_ready = issue_rd == '0 & ~issue_is_branch & ~issue_is_store;
  assign cslot      = slot(cdb_rob_id);
  assign cdb_hit    = live & cdb_valid & tag_ok(cdb_rob_id) & busy_q[cslot];
  assign do_commit  = live & busy_q[head_q] & ready_q[head_q];
  assign mispredict = do_commit & br_q[head_q] & (tk_q[head_q] != pt_q[head_q]);

  assign q1s          = slot(query1_id);
  assign q2s          = slot(query2_id);
  assign q1_byp       = cdb_valid & cdb_rob_id == query1_id & tag_ok(query1_id) & busy_q[q1s];
  assign q2_byp       = cdb_valid & cdb_rob_id == query2_id & tag_ok(query2_id) & busy_q[q2s];
  assign query1_ready = q1_byp | (tag_ok(query1_id) & busy_q[q1s] & ready_q[q1s]);
  assign query2_ready = q2_byp | (tag_ok(query2_id) & busy_q[q2s] & ready_q[q2s]);
  assign query1_value = q1_byp ? cdb_value : query1_ready ? val_q[q1s] : DATA_RESET;
  assign query2_value = q2_byp ? cdb_value : query2_ready ? val_q[q2s] : DATA_RESET;

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (do_issue) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = auto_ready;
      tail_d          = tail_q + STEP;
    end
    if (cdb_hit) ready_d[cslot] = 1'b1;
    if (do_commit) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + STEP;
    end
    count_d = count_q + CW'(do_issue) - CW'(do_commit);
    if (flush_q) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    cflag_d = do_commit;
    cst_d   = do_commit & st_q[head_q];
    crd_d   = do_commit & ~st_q[head_q] ? rd_q[head_q] : REG_RESET;
    cval_d  = do_commit ? val_q[head_q] : DATA_RESET;
    cid_d   = do_commit ? ROB_ID_W'(head_q) + ONE : ROB_ID_W'(ROB_ID_RESET);
    rb_d    = mispredict;
    rbpc_d  = mispredict ? pc_q[head_q] : DATA_RESET;
    flush_d = mispredict;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q  <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
      cflag_q <= 1'b0;
      cst_q   <= 1'b0;
      crd_q   <= REG_RESET;
      cval_q  <= DATA_RESET;
      cid_q   <= ROB_ID_W'(ROB_ID_RESET);
      rb_q    <= 1'b0;
      rbpc_q  <= DATA_RESET;
    end else if (rdy_in) begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      flush_q <= flush_d;
      cflag_q <= cflag_d;
      cst_q   <= cst_d;
      crd_q   <= crd_d;
      cval_q  <= cval_d;
      cid_q   <= cid_d;
      rb_q    <= rb_d;
      rbpc_q  <= rbpc_d;
    end
  end

  // Payload needs no reset: it is only observed through busy/ready
  always_ff @(posedge clk_in) begin
    if (do_issue) begin
      rd_q[tail_q]  <= issue_rd;
      pc_q[tail_q]  <= issue_alt_pc;
      val_q[tail_q] <= DATA_RESET;
      br_q[tail_q]  <= issue_is_branch;
      pt_q[tail_q]  <= issue_pred_taken;
      st_q[tail_q]  <= issue_is_store;
      tk_q[tail_q]  <= 1'b0;
    end
    if (cdb_hit) begin
      val_q[cslot] <= cdb_value;
      tk_q[cslot]  <= cdb_taken;
    end
  end

  assign commit_flag   = cflag_q;
  assign commit_rd     = crd_q;
  assign commit_value  = cval_q;
  assign commit_rob_id = cid_q;
  assign store_commit  = cst_q;
  assign rollback_flag = rb_q;
  assign rollback_pc   = rbpc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench checking in-order commit, full, bypass, rollback and reset
module tb_reorder_buffer;
  logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
  logic        issue_valid = 1'b0, issue_is_branch = 1'b0, issue_pred_taken = 1'b0, issue_is_store = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] issue_alt_pc = '0;
  logic [4:0]  new_rob_id, query1_id = '0, query2_id = '0, cdb_rob_id = '0, commit_rob_id, commit_rd;
  logic        rob_full, query1_ready, query2_ready, commit_flag, store_commit, rollback_flag;
  logic [31:0] query1_value, query2_value, cdb_value = '0, commit_value, rollback_pc;
  logic        cdb_valid = 1'b0, cdb_taken = 1'b0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [4:0]  id;
    logic        st;
    logic        rb;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_errors = 0, mtail = 0;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc), .issue_is_store(issue_is_store),
    .new_rob_id(new_rob_id), .rob_full(rob_full),
    .query1_id(query1_id), .query2_id(query2_id),
    .query1_ready(query1_ready), .query1_value(query1_value),
    .query2_ready(query2_ready), .query2_value(query2_value),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
    .commit_flag(commit_flag), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_rob_id(commit_rob_id), .store_commit(store_commit),
    .rollback_flag(rollback_flag), .rollback_pc(rollback_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    rst_in = 1'b1;
    issue_valid = 1'b0;
    cdb_valid = 1'b0;
    tick();
    sb.delete();
    mtail = 0;
    rst_in = 1'b0;
    tick();
  endtask

  task automatic issue(input logic [4:0] rd, input logic br, input logic pt, input logic [31:0] pc,
                       input logic st, input logic [31:0] val, input logic tk, input logic acc);
    exp_t e;
    issue_valid = 1'b1;
    issue_rd = rd;
    issue_is_branch = br;
    issue_pred_taken = pt;
    issue_alt_pc = pc;
    issue_is_store = st;
    if (acc) begin
      check("new_rob_id", 32'(new_rob_id), 32'(mtail + 1));
      e.rd = st ? 5'd0 : rd;
      e.val = val;
      e.id = 5'(mtail + 1);
      e.st = st;
      e.rb = br && (tk != pt);
      e.pc = pc;
      sb.push_back(e);
      mtail = (mtail + 1) % 16;
    end
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] id, input logic [31:0] val, input logic tk);
    cdb_valid = 1'b1;
    cdb_rob_id = id;
    cdb_value = val;
    cdb_taken = tk;
    tick();
    cdb_valid = 1'b0;
  endtask

  always @(negedge clk_in) begin : mon
    exp_t e;
    if (!rst_in && rdy_in) begin
      if (commit_flag) begin
        if (sb.size() == 0) check("unexpected_commit", 32'(commit_rob_id), 32'd0);
        else begin
          e = sb.pop_front();
          check("commit_rob_id", 32'(commit_rob_id), 32'(e.id));
          check("commit_rd", 32'(commit_rd), 32'(e.rd));
          check("commit_value", commit_value, e.val);
          check("store_commit", 32'(store_commit), 32'(e.st));
          check("rollback_flag", 32'(rollback_flag), 32'(e.rb));
          if (e.rb) check("rollback_pc", rollback_pc, e.pc);
        end
      end else check("idle_pulses", {30'd0, store_commit, rollback_flag}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] tg;
    tick();
    tick();
    check("rst_new_id", 32'(new_rob_id), 32'd1);
    check("rst_full", 32'(rob_full), 32'd0);
    check("rst_commit", 32'(commit_flag), 32'd0);
    check("rst_store", 32'(store_commit), 32'd0);
    check("rst_rollback", 32'(rollback_flag), 32'd0);
    check("rst_rb_pc", rollback_pc, 32'd0);
    check("rst_q1_ready", 32'(query1_ready), 32'd0);
    check("rst_q1_value", query1_value, 32'd0);
    rst_in = 1'b0;
    tick();
    rdy_in = 1'b0;
    issue_valid = 1'b1;
    issue_rd = 5'd4;
    tick();
    tick();
    issue_valid = 1'b0;
    rdy_in = 1'b1;
    check("freeze_id", 32'(new_rob_id), 32'd1);
    issue(5'd5, 0, 0, 0, 0, 32'h1234, 0, 1);
    cdb(5'd1, 32'h1234, 0);
    check("lat1_flag", 32'(commit_flag), 32'd0);
    tick();
    check("lat2_flag", 32'(commit_flag), 32'd1);
    check("lat2_rd", 32'(commit_rd), 32'd5);
    check("lat2_value", commit_value, 32'h1234);
    tick();
    check("pulse_once", 32'(commit_flag), 32'd0);
    issue(5'd1, 0, 0, 0, 0, 32'h11, 0, 1);
    issue(5'd2, 0, 0, 0, 0, 32'h22, 0, 1);
    cdb(5'd3, 32'h22, 0);
    cdb(5'd2, 32'h11, 0);
    check("ooo_blocked", 32'(commit_flag), 32'd0);
    tick();
    check("ooo_first", 32'(commit_rob_id), 32'd2);
    tick();
    check("ooo_second_flag", 32'(commit_flag), 32'd1);
    check("ooo_second", 32'(commit_rob_id), 32'd3);
    tick();
    issue(5'd9, 0, 0, 0, 1, 32'hab, 0, 1);
    cdb(5'd4, 32'hab, 0);
    tick();
    check("store_pulse", 32'(store_commit), 32'd1);
    issue(5'd0, 1, 1, 32'h200, 0, 32'h0, 1, 1);
    cdb(5'd5, 32'h0, 1);
    tick();
    check("br_ok_no_rb", 32'(rollback_flag), 32'd0);
    tick();
    do_reset();
    issue(5'd0, 1, 0, 32'h100, 0, 32'h0, 1, 1);
    issue(5'd7, 0, 0, 0, 0, 32'h9, 0, 1);
    query1_id = 5'd2;
    cdb(5'd2, 32'h9, 0);
    check("young_ready", 32'(query1_ready), 32'd1);
    check("young_value", query1_value, 32'h9);
    cdb(5'd1, 32'h0, 1);
    tick();
    check("rb_flag", 32'(rollback_flag), 32'd1);
    check("rb_pc", rollback_pc, 32'h100);
    check("rb_commit", 32'(commit_flag), 32'd1);
    issue_valid = 1'b1;
    issue_rd = 5'd3;
    issue_is_branch = 1'b0;
    issue_is_store = 1'b0;
    cdb_valid = 1'b1;
    cdb_rob_id = 5'd3;
    tick();
    issue_valid = 1'b0;
    cdb_valid = 1'b0;
    sb.delete();
    mtail = 0;
    check("flush_new_id", 32'(new_rob_id), 32'd1);
    check("flush_q_old", 32'(query1_ready), 32'd0);
    check("flush_rb_clear", 32'(rollback_flag), 32'd0);
    check("flush_no_commit", 32'(commit_flag), 32'd0);
    tick();
    check("flush_stays_empty", 32'(commit_flag), 32'd0);
    for (int i = 1; i <= 15; i++) issue(5'(i), 0, 0, 0, 0, 32'(i * 3), 0, 1);
    check("full_set", 32'(rob_full), 32'd1);
    check("full_id", 32'(new_rob_id), 32'd16);
    issue(5'd20, 0, 0, 0, 0, 0, 0, 0);
    check("full_ignored", 32'(new_rob_id), 32'd16);
    for (int t = 1; t <= 15; t++) begin
      query1_id = 5'(t);
      query2_id = 5'(t + 1);
      cdb_valid = 1'b1;
      cdb_rob_id = 5'(t);
      cdb_value = 32'(t * 3);
      cdb_taken = 1'b0;
      #1;
      check("bypass_ready", 32'(query1_ready), 32'd1);
      check("bypass_value", query1_value, 32'(t * 3));
      check("q2_not_ready", 32'(query2_ready), 32'd0);
      check("q2_zero", query2_value, 32'd0);
      tick();
      if (t == 1) check("full_hold", 32'(rob_full), 32'd1);
      if (t == 2) check("full_cleared", 32'(rob_full), 32'd0);
    end
    cdb_valid = 1'b0;
    query1_id = '0;
    query2_id = '0;
    repeat (3) tick();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tg = 5'(mtail + 1);
      issue(5'((i % 31) + 1), 0, 0, 0, 0, 32'(i * 7 + 1), 0, 1);
      cdb(tg, 32'(i * 7 + 1), 0);
      check("wrap_not_full", 32'(rob_full), 32'd0);
    end
    repeat (3) tick();
    tg = 5'(mtail + 1);
    issue(5'd3, 0, 0, 0, 0, 32'h55, 0, 1);
    cdb(tg, 32'h55, 0);
    rst_in = 1'b1;
    sb.delete();
    mtail = 0;
    query1_id = tg;
    #1;
    check("arst_commit", 32'(commit_flag), 32'd0);
    check("arst_new_id", 32'(new_rob_id), 32'd1);
    check("arst_query", 32'(query1_ready), 32'd0);
    tick();
    check("arst_no_pulse", 32'(commit_flag), 32'd0);
    rst_in = 1'b0;
    query1_id = '0;
    tick();
    for (int k = 0; k < 50 && sb.size() != 0; k++) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_SIZE, default 16, entry count (power of two).
REQ-002 Parameter ROB_ID_W, default 5, tag width; tag = slot index + 1, tag 0 = "no producer".
REQ-003 clk_in  in  1  single clock; all state on its rising edge.
REQ-004 rst_in  in  1  reset, asynchronous, active-high.
REQ-005 rdy_in  in  1  global enable; low freezes all state and holds outputs.
REQ-006 issue_valid  in  1  dispatcher allocates an entry this cycle.
REQ-007 issue_rd  in  5  destination register; 0 = none.
REQ-008 issue_is_branch  in  1  entry is a conditional branch.
REQ-009 issue_pred_taken  in  1  predicted direction.
REQ-010 issue_alt_pc  in  32  PC to restart at if the prediction is wrong.
REQ-011 issue_is_store  in  1  entry is a store.
REQ-012 new_rob_id  out  ROB_ID_W  tag the next allocation receives.
REQ-013 rob_full  out  1  no allocation is accepted.
REQ-014 query1_id, query2_id  in  ROB_ID_W each  operand tags from the dispatcher.
REQ-015 query1_ready/query1_value, query2_ready/query2_value  out  1/32  operand forwarding.
REQ-016 cdb_valid, cdb_rob_id, cdb_value, cdb_taken  in  1/ROB_ID_W/32/1  result write-back.
REQ-017 commit_flag, commit_rd, commit_value, commit_rob_id  out  1/5/32/ROB_ID_W  to the register file.
REQ-018 store_commit  out  1  head store retired; the load/store unit may write memory.
REQ-019 rollback_flag, rollback_pc  out  1/32  flush on misprediction.

Function
REQ-020 Circular buffer with head, tail and count; new_rob_id = tail+1.
REQ-021 rob_full = (count >= ROB_SIZE-1); one slot of slack covers the one-cycle dispatch pipeline.
REQ-022 Issue with issue_valid high and not rob_full writes the tail entry (busy, not ready) and advances tail, wrapping modulo ROB_SIZE.
REQ-023 Issue while rob_full is ignored and changes no state.
REQ-024 Entries with issue_rd=0 that are neither branch nor store are marked ready at issue.
REQ-025 cdb_valid marks entry cdb_rob_id ready and stores value/taken; a write to a non-busy entry or to tag 0 is ignored.
REQ-026 Query output: ready=1 and value = entry value if that entry is ready.
  - If cdb_valid and cdb_rob_id equals the query tag in the same cycle, ready=1 and value=cdb_value (bypass).
  - Query tag 0 gives ready=0 and value=0.
REQ-027 Commit: when head entry is busy and ready, it retires in one cycle; head advances and count decrements.
REQ-028 Commit outputs are registered and valid for exactly one cycle after the retiring edge; commit_flag is otherwise 0.
REQ-029 Minimum latency from a cdb write to commit_flag high is 2 cycles.
REQ-030 Non-store, non-branch commit: commit_flag=1, commit_rd, commit_value, commit_rob_id.
REQ-031 Store commit: store_commit=1 and commit_flag=1 with commit_rd=0.
REQ-032 Branch commit:
  - Correct prediction (cdb_taken == issue_pred_taken): plain commit.
  - Wrong prediction: commit_flag=1 and rollback_flag=1 for one cycle, rollback_pc = alt_pc.
  - Next edge after a wrong prediction: all entries clear, head=tail=count=0; issue and cdb in that cycle are ignored.
REQ-033 Issue and commit in the same cycle leave count unchanged; both pointers advance.
REQ-034 At most one commit per cycle; a non-ready head blocks all younger entries.

Reset
REQ-035 During rst_in, all entries are non-busy, head=tail=count=0, and every output is 0 except new_rob_id=1.
REQ-036 Reset asserted mid-operation discards all entries immediately; no commit or rollback pulse is emitted.

Structure
REQ-037 The shared constants package holds DATA_TYPE, REG_TYPE, ROB_ID_TYPE, ROB_SIZE, ROB_ID_RESET, REG_RESET and DATA_RESET.
REQ-038 A single flat module; no sub-module is needed (entry arrays plus pointer logic).

Verification
REQ-039 Issue rd=5, cdb value 0x1234 -> two cycles later: commit_flag=1, commit_rd=5, commit_value=0x1234, commit_rob_id=1.
REQ-040 15 issues without write-back -> rob_full=1; a 16th issue is ignored; the first commit clears rob_full.
REQ-041 Branch with pred_taken=0, cdb_taken=1, alt_pc=0x100 -> rollback_flag=1, rollback_pc=0x100; next cycle new_rob_id=1 and query of any old tag gives ready=0.
REQ-042 cdb tag 3 value 7 while query1_id=3 in the same cycle -> query1_ready=1, query1_value=7.
REQ-043 Results written back out of order (tags 2 then 1) -> commits occur in order 1 then 2 on consecutive cycles.
REQ-044 Wrap-around: 40 issue/commit pairs -> tags cycle 1..16 and count stays ≤1.
